data_bus_arbiter: RTL and testbench

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

---
 rtl/data_bus_arbiter_pkg.sv | 14 +
 rtl/data_bus_arbiter_arb_select.sv | 32 +++
 rtl/data_bus_arbiter.sv | 92 +++++++++
 tb/tb_data_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the two-master data bus arbiter: FSM state encoding
// and master index constants.
package data_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP0 = 2'd1,
    RESP1 = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/data_bus_arbiter_arb_select.sv
// Combinational winner selection between two requesters.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin; otherwise m0 has fixed priority.
module arb_select
  import data_bus_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       winner_o
);

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    valid_o  = |req_i;
    winner_o = M0;
    unique case (req_i)
      2'b01:   winner_o = M0;
      2'b10:   winner_o = M1;
`ifdef ARB_ROUND_ROBIN_EN
      2'b11:   winner_o = (last_grant_i == M0) ? M1 : M0;
`else
      2'b11:   winner_o = M0;
`endif
      default: winner_o = M0;
    endcase
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master single-slave bus arbiter with one outstanding transaction.
// Build option: ARB_ROUND_ROBIN_EN enables round-robin conflict resolution.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wd,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rd,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wd,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rd,
  output logic                  s_we,
  output logic                  s_re,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wd,
  input  logic [DATA_WIDTH-1:0] s_rd,
  output logic                  core_stall
);

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   sel_valid, sel_winner;
  logic   grant, win_we;

  arb_select u_arb_select (
    .req_i        ({m1_req, m0_req}),
    .last_grant_i (last_grant_q),
    .valid_o      (sel_valid),
    .winner_o     (sel_winner)
  );

  // Grant logic is qualified by rst_n so every output reads 0 while reset is held.
  assign grant  = (state_q == IDLE) && sel_valid && rst_n;
  assign win_we = (sel_winner == M1) ? m1_we : m0_we;

  always_comb begin
    m0_gnt    = grant && (sel_winner == M0);
    m1_gnt    = grant && (sel_winner == M1);
    s_we      = grant && win_we;
    s_re      = grant && !win_we;
    s_addr    = '0;
    s_wd      = '0;
    if (grant) begin
      s_addr = (sel_winner == M1) ? m1_addr : m0_addr;
      s_wd   = (sel_winner == M1) ? m1_wd   : m0_wd;
    end
    m0_rvalid  = (state_q == RESP0);
    m1_rvalid  = (state_q == RESP1);
    m0_rd      = m0_rvalid ? s_rd : '0;
    m1_rd      = m1_rvalid ? s_rd : '0;
    core_stall = rst_n && m0_req && !(m0_gnt && m0_we) && !m0_rvalid;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          last_grant_d = sel_winner;
          if (!win_we) state_d = (sel_winner == M1) ? RESP1 : RESP0;
        end
      end
      RESP0, RESP1: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= M1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed self-checking bench for data_bus_arbiter (default or round-robin build).
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rd, m1_rd;
  logic        s_we, s_re;
  logic [31:0] s_addr, s_wd;
  logic [31:0] s_rd;
  logic        core_stall;
  logic [31:0] slave_data;

  int checks   = 0;
  int failures = 0;

  // {m0_gnt, m1_gnt, s_we, s_re, m0_rvalid, m1_rvalid, core_stall}
  logic [6:0] ctl;
  assign ctl = {m0_gnt, m1_gnt, s_we, s_re, m0_rvalid, m1_rvalid, core_stall};

  always #5 clk = ~clk;

  // Slave returns slave_data the cycle after a read strobe, all ones otherwise.
  always @(posedge clk) s_rd <= s_re ? slave_data : 32'hFFFF_FFFF;

  data_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
    .s_we(s_we), .s_re(s_re), .s_addr(s_addr), .s_wd(s_wd), .s_rd(s_rd),
    .core_stall(core_stall)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wd = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wd = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 0;
    next_cycle();
    rst_n = 1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    next_cycle();
    m0_req = 1; m0_we = 0; m0_addr = 32'h1234_0000; m0_wd = 32'h1111_1111;
    m1_req = 1; m1_we = 1; m1_addr = 32'h5678_0000; m1_wd = 32'h2222_2222;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0) begin
      failures++; $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0);
    end
    checks++;
    if ({s_addr, s_wd, m0_rd, m1_rd} !== 128'b0) begin
      failures++; $display("FAIL reset_buses: s_addr=%h s_wd=%h m0_rd=%h m1_rd=%h want 0",
                           s_addr, s_wd, m0_rd, m1_rd);
    end
    next_cycle();
    idle_inputs();
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== 7'b0 || s_addr !== 32'h0) begin
        failures++; $display("FAIL idle_after_reset cycle %0d: ctl=%b s_addr=%h want 0", i, ctl, s_addr);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_write;
    m0_req = 1; m0_we = 1; m0_addr = 32'h1000_0010; m0_wd = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b1010000) begin
      failures++; $display("FAIL write_ctl: got %b want %b", ctl, 7'b1010000);
    end
    checks++;
    if (s_addr !== 32'h1000_0010 || s_wd !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL write_bus: s_addr=%h s_wd=%h want 10000010 deadbeef", s_addr, s_wd);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0) begin
      failures++; $display("FAIL write_returns_idle: got %b want %b", ctl, 7'b0);
    end
    next_cycle();
  endtask

  task automatic test_single_read;
    slave_data = 32'h0000_00A5;
    m1_req = 1; m1_we = 0; m1_addr = 32'h1000_0004;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0101000 || s_addr !== 32'h1000_0004) begin
      failures++; $display("FAIL read_grant: ctl=%b s_addr=%h want %b 10000004", ctl, s_addr, 7'b0101000);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0000010) begin
      failures++; $display("FAIL read_resp_ctl: got %b want %b", ctl, 7'b0000010);
    end
    checks++;
    if (m1_rd !== 32'h0000_00A5 || m0_rd !== 32'h0) begin
      failures++; $display("FAIL read_resp_data: m1_rd=%h m0_rd=%h want 000000a5 0", m1_rd, m0_rd);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_conflict;
    logic [6:0] exp_t [8];
`ifdef ARB_ROUND_ROBIN_EN
    exp_t = '{7'b1001001, 7'b0000100, 7'b0101001, 7'b0000011,
              7'b1001001, 7'b0000100, 7'b0101001, 7'b0000011};
`else
    exp_t = '{7'b1001001, 7'b0000100, 7'b1001001, 7'b0000100,
              7'b1001001, 7'b0000100, 7'b1001001, 7'b0000100};
`endif
    do_reset();
    slave_data = 32'h5555_0001;
    m0_req = 1; m0_we = 0; m0_addr = 32'h2000_0000;
    m1_req = 1; m1_we = 0; m1_addr = 32'h3000_0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== exp_t[i]) begin
        failures++; $display("FAIL conflict_ctl cycle %0d: got %b want %b", i, ctl, exp_t[i]);
      end
      checks++;
      if (m0_rd !== (exp_t[i][2] ? slave_data : 32'h0) ||
          m1_rd !== (exp_t[i][1] ? slave_data : 32'h0)) begin
        failures++; $display("FAIL conflict_rd cycle %0d: m0_rd=%h m1_rd=%h", i, m0_rd, m1_rd);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_stall;
    logic       m0r [4];
    logic       m1r [4];
    logic [6:0] exp_t [4];
    do_reset();
    slave_data = 32'h0BAD_F00D;
`ifdef ARB_ROUND_ROBIN_EN
    // An m0 write first so the next conflict goes to m1.
    m0_req = 1; m0_we = 1; m0_addr = 32'h4000_0000; m0_wd = 32'h1;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b1010000) begin
      failures++; $display("FAIL stall_prewrite: got %b want %b", ctl, 7'b1010000);
    end
    next_cycle();
    m0r   = '{1'b1, 1'b1, 1'b1, 1'b1};
    m1r   = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_t = '{7'b0101001, 7'b0000011, 7'b1001001, 7'b0000100};
`else
    m0r   = '{1'b0, 1'b1, 1'b1, 1'b1};
    m1r   = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_t = '{7'b0101000, 7'b0000011, 7'b1001001, 7'b0000100};
`endif
    m0_we = 0; m0_addr = 32'h4000_0008;
    m1_we = 0; m1_addr = 32'h5000_0008;
    for (int i = 0; i < 4; i++) begin
      m0_req = m0r[i];
      m1_req = m1r[i];
      @(negedge clk);
      checks++;
      if (ctl !== exp_t[i]) begin
        failures++; $display("FAIL stall_ctl cycle %0d: got %b want %b", i, ctl, exp_t[i]);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_read;
    slave_data = 32'h0000_0077;
    m1_req = 1; m1_we = 0; m1_addr = 32'h6000_0000;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0101000) begin
      failures++; $display("FAIL midrst_grant: got %b want %b", ctl, 7'b0101000);
    end
    next_cycle();
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0 || m1_rd !== 32'h0) begin
      failures++; $display("FAIL midrst_no_rvalid: ctl=%b m1_rd=%h want 0", ctl, m1_rd);
    end
    next_cycle();
    rst_n = 1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h7000_0000;
    m1_req = 1; m1_we = 0; m1_addr = 32'h6000_0000;
    @(negedge clk);
    checks++;
    if (ctl !== 7'b1001001) begin
      failures++; $display("FAIL midrst_conflict: got %b want %b", ctl, 7'b1001001);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ctl !== 7'b0000100 || m0_rd !== 32'h0000_0077) begin
      failures++; $display("FAIL midrst_resp0: ctl=%b m0_rd=%h want %b 00000077", ctl, m0_rd, 7'b0000100);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back;
    logic [31:0] addr_t [4];
    logic [31:0] data_t [4];
    addr_t = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C};
    data_t = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    for (int i = 0; i < 4; i++) begin
      m0_req = 1; m0_we = 1; m0_addr = addr_t[i]; m0_wd = data_t[i];
      @(negedge clk);
      checks++;
      if (ctl !== 7'b1010000 || s_addr !== addr_t[i] || s_wd !== data_t[i]) begin
        failures++; $display("FAIL b2b_write %0d: ctl=%b s_addr=%h s_wd=%h want %b %h %h",
                             i, ctl, s_addr, s_wd, 7'b1010000, addr_t[i], data_t[i]);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    slave_data = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_conflict();
    test_stall();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
